// File: rtl/pcc_stream_acc.sv
// ---------------------------------------------------------------------------
// pcc_stream_acc
//
// Streaming popcount comparator. A frame is one or more beats, each carrying
// POS_W "positive" and NEG_W "negative" bits. Both popcounts are accumulated
// across the frame (saturating) and one decision is emitted per frame:
// total positive count >= total negative count.
//
// Optional build macro: PCC_TRUNC_EN
//   defined   -> the decision compares (P >> TRUNC) >= (N >> TRUNC)
//   undefined -> exact compare (TRUNC only range-checked)
//   Reported totals are never truncated.
//
// Ports:
//   i_clk           clock, rising edge
//   i_rst_n         synchronous reset, active low
//   i_in_valid      beat present
//   o_in_ready      block can accept a beat (state only, not in_valid)
//   i_in_pos        positive bits of the beat   [POS_W]
//   i_in_neg        negative bits of the beat   [NEG_W]
//   i_in_last       beat closes the frame
//   o_out_valid     frame result present
//   i_out_ready     consumer takes the result
//   o_out_val       decision: pos_total >= neg_total
//   o_out_pos_cnt   frame positive total, saturated   [ACC_W]
//   o_out_neg_cnt   frame negative total, saturated   [ACC_W]
//   o_out_beats     beats in frame, saturated         [BEAT_W]
//   o_out_ovf       some counter saturated during the frame
// ---------------------------------------------------------------------------
module pcc_stream_acc #(
    parameter int POS_W  = 5,
    parameter int NEG_W  = 2,
    parameter int ACC_W  = 8,
    parameter int BEAT_W = 6,
    parameter int TRUNC  = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [POS_W-1:0]  i_in_pos,
    input  logic [NEG_W-1:0]  i_in_neg,
    input  logic              i_in_last,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_out_val,
    output logic [ACC_W-1:0]  o_out_pos_cnt,
    output logic [ACC_W-1:0]  o_out_neg_cnt,
    output logic [BEAT_W-1:0] o_out_beats,
    output logic              o_out_ovf
);

    localparam int PC_PW = $clog2(POS_W + 1);
    localparam int PC_NW = $clog2(NEG_W + 1);

    localparam logic [0:0] S_ACCUM = 1'b0;
    localparam logic [0:0] S_HOLD  = 1'b1;

    // Elaboration-time guard: a shift of ACC_W or more would zero both sides.
    generate
        if (TRUNC < 0 || TRUNC >= ACC_W) begin : g_bad_trunc
            $error("pcc_stream_acc: TRUNC must be in [0, ACC_W)");
        end
    endgenerate

    logic [0:0]        r_state;
    logic [ACC_W-1:0]  r_acc_pos;
    logic [ACC_W-1:0]  r_acc_neg;
    logic [BEAT_W-1:0] r_beats;
    logic              r_ovf;

    logic              r_out_valid;
    logic              r_out_val;
    logic [ACC_W-1:0]  r_out_pos;
    logic [ACC_W-1:0]  r_out_neg;
    logic [BEAT_W-1:0] r_out_beats;
    logic              r_out_ovf;

    logic [PC_PW-1:0]  w_pos_pc;
    logic [PC_NW-1:0]  w_neg_pc;
    logic [ACC_W:0]    w_pos_sum;
    logic [ACC_W:0]    w_neg_sum;
    logic [BEAT_W:0]   w_beat_sum;
    logic              w_pos_sat;
    logic              w_neg_sat;
    logic              w_beat_sat;
    logic [ACC_W-1:0]  w_pos_nxt;
    logic [ACC_W-1:0]  w_neg_nxt;
    logic [BEAT_W-1:0] w_beats_nxt;
    logic              w_ovf_nxt;
    logic              w_val;
    logic              w_accept;

    assign o_in_ready = (r_state == S_ACCUM);
    assign w_accept   = i_in_valid && o_in_ready;

    // Popcounts of the current beat.
    always_comb begin
        w_pos_pc = '0;
        for (int i = 0; i < POS_W; i++)
            w_pos_pc = w_pos_pc + PC_PW'(i_in_pos[i]);
    end

    always_comb begin
        w_neg_pc = '0;
        for (int i = 0; i < NEG_W; i++)
            w_neg_pc = w_neg_pc + PC_NW'(i_in_neg[i]);
    end

    // One extra bit on each sum exposes the carry used as the saturation flag.
    assign w_pos_sum  = {1'b0, r_acc_pos} + (ACC_W+1)'(w_pos_pc);
    assign w_neg_sum  = {1'b0, r_acc_neg} + (ACC_W+1)'(w_neg_pc);
    assign w_beat_sum = {1'b0, r_beats} + (BEAT_W+1)'(1);

    assign w_pos_sat  = w_pos_sum[ACC_W];
    assign w_neg_sat  = w_neg_sum[ACC_W];
    assign w_beat_sat = w_beat_sum[BEAT_W];

    assign w_pos_nxt   = w_pos_sat  ? '1 : w_pos_sum[ACC_W-1:0];
    assign w_neg_nxt   = w_neg_sat  ? '1 : w_neg_sum[ACC_W-1:0];
    assign w_beats_nxt = w_beat_sat ? '1 : w_beat_sum[BEAT_W-1:0];
    assign w_ovf_nxt   = r_ovf | w_pos_sat | w_neg_sat | w_beat_sat;

    // Decision on the totals including the current beat, so a last beat can
    // register its result in the same cycle it is accepted.
`ifdef PCC_TRUNC_EN
    assign w_val = (w_pos_nxt >> TRUNC) >= (w_neg_nxt >> TRUNC);
`else
    assign w_val = (w_pos_nxt >= w_neg_nxt);
`endif

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_ACCUM;
            r_acc_pos   <= '0;
            r_acc_neg   <= '0;
            r_beats     <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_val   <= 1'b0;
            r_out_pos   <= '0;
            r_out_neg   <= '0;
            r_out_beats <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_ACCUM: begin
                    if (w_accept) begin
                        if (i_in_last) begin
                            r_out_valid <= 1'b1;
                            r_out_val   <= w_val;
                            r_out_pos   <= w_pos_nxt;
                            r_out_neg   <= w_neg_nxt;
                            r_out_beats <= w_beats_nxt;
                            r_out_ovf   <= w_ovf_nxt;
                            r_acc_pos   <= '0;
                            r_acc_neg   <= '0;
                            r_beats     <= '0;
                            r_ovf       <= 1'b0;
                            r_state     <= S_HOLD;
                        end else begin
                            r_acc_pos <= w_pos_nxt;
                            r_acc_neg <= w_neg_nxt;
                            r_beats   <= w_beats_nxt;
                            r_ovf     <= w_ovf_nxt;
                        end
                    end
                end
                S_HOLD: begin
                    // Result registers keep their value after the handshake;
                    // only out_valid qualifies them.
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_ACCUM;
                    end
                end
                default: r_state <= S_ACCUM;
            endcase
        end
    end

    assign o_out_valid   = r_out_valid;
    assign o_out_val     = r_out_val;
    assign o_out_pos_cnt = r_out_pos;
    assign o_out_neg_cnt = r_out_neg;
    assign o_out_beats   = r_out_beats;
    assign o_out_ovf     = r_out_ovf;

endmodule

// File: tb/tb_pcc_stream_acc.sv
module tb_pcc_stream_acc;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_in_valid;
    logic       o_in_ready;
    logic [4:0] i_in_pos;
    logic [1:0] i_in_neg;
    logic       i_in_last;
    logic       o_out_valid;
    logic       i_out_ready;
    logic       o_out_val;
    logic [7:0] o_out_pos_cnt;
    logic [7:0] o_out_neg_cnt;
    logic [5:0] o_out_beats;
    logic       o_out_ovf;

    typedef struct {
        int val;
        int pos;
        int neg;
        int beats;
        int ovf;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 i_clk = ~i_clk;

    pcc_stream_acc #(.POS_W(5), .NEG_W(2), .ACC_W(8), .BEAT_W(6), .TRUNC(1)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_in_valid   (i_in_valid),
        .o_in_ready   (o_in_ready),
        .i_in_pos     (i_in_pos),
        .i_in_neg     (i_in_neg),
        .i_in_last    (i_in_last),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (i_out_ready),
        .o_out_val    (o_out_val),
        .o_out_pos_cnt(o_out_pos_cnt),
        .o_out_neg_cnt(o_out_neg_cnt),
        .o_out_beats  (o_out_beats),
        .o_out_ovf    (o_out_ovf)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int val, input int pos, input int neg, input int beats, input int ovf);
        exp_t e;
        e.val = val; e.pos = pos; e.neg = neg; e.beats = beats; e.ovf = ovf;
        q.push_back(e);
    endtask

    // Drives one beat and returns #1 after the edge that accepted it.
    task automatic send_beat(input logic [4:0] pos, input logic [1:0] neg, input logic last);
        logic rdy;
        int   n;
        i_in_valid = 1'b1;
        i_in_pos   = pos;
        i_in_neg   = neg;
        i_in_last  = last;
        n = 0;
        rdy = 1'b0;
        while (!rdy && n < 100) begin
            @(negedge i_clk);
            rdy = o_in_ready;
            @(posedge i_clk);
            #1;
            n++;
        end
        if (!rdy) chk("accept_timeout", 0, 1);
        i_in_valid = 1'b0;
        i_in_last  = 1'b0;
    endtask

    // Monitor: one pop per output handshake.
    always @(negedge i_clk) begin
        if (i_rst_n === 1'b1 && o_out_valid && i_out_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("out_val",     int'(o_out_val),     e.val);
                chk("out_pos_cnt", int'(o_out_pos_cnt), e.pos);
                chk("out_neg_cnt", int'(o_out_neg_cnt), e.neg);
                chk("out_beats",   int'(o_out_beats),   e.beats);
                chk("out_ovf",     int'(o_out_ovf),     e.ovf);
            end
        end
    end

    initial begin
        i_rst_n     = 1'b0;
        i_in_valid  = 1'b0;
        i_in_pos    = '0;
        i_in_neg    = '0;
        i_in_last   = 1'b0;
        i_out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_out_valid", int'(o_out_valid),   0);
        chk("rst_out_val",   int'(o_out_val),     0);
        chk("rst_pos_cnt",   int'(o_out_pos_cnt), 0);
        chk("rst_neg_cnt",   int'(o_out_neg_cnt), 0);
        chk("rst_beats",     int'(o_out_beats),   0);
        chk("rst_ovf",       int'(o_out_ovf),     0);
        chk("rst_in_ready",  int'(o_in_ready),    1);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;

        // Single-beat frame: P=3, N=2
        push(1, 3, 2, 1, 0);
        send_beat(5'b10110, 2'b11, 1'b1);
        chk("latency_out_valid", int'(o_out_valid), 1);

        // 3-beat frame P=2, N=3, with backpressure on the result
        send_beat(5'b00001, 2'b11, 1'b0);
        send_beat(5'b00000, 2'b01, 1'b0);
        i_out_ready = 1'b0;
`ifdef PCC_TRUNC_EN
        push(1, 2, 3, 3, 0);
`else
        push(0, 2, 3, 3, 0);
`endif
        send_beat(5'b10000, 2'b00, 1'b1);
        chk("pending_in_ready", int'(o_in_ready), 0);
        for (int i = 0; i < 5; i++) begin
            // A beat offered during HOLD must not be consumed.
            i_in_valid = 1'b1;
            i_in_pos   = 5'b11111;
            i_in_neg   = 2'b00;
            i_in_last  = 1'b1;
            @(negedge i_clk);
            chk("bp_in_ready",  int'(o_in_ready),    0);
            chk("bp_out_valid", int'(o_out_valid),   1);
            chk("bp_pos_cnt",   int'(o_out_pos_cnt), 2);
            chk("bp_neg_cnt",   int'(o_out_neg_cnt), 3);
            chk("bp_beats",     int'(o_out_beats),   3);
            @(posedge i_clk);
            #1;
        end
        i_in_valid  = 1'b0;
        i_in_last   = 1'b0;
        i_out_ready = 1'b1;
        @(posedge i_clk);
        #1;
        chk("release_out_valid", int'(o_out_valid), 0);
        chk("release_in_ready",  int'(o_in_ready),  1);

        // Saturation: 60 x 5 = 300 clamps to 255
        push(1, 255, 0, 60, 1);
        for (int i = 0; i < 60; i++)
            send_beat(5'b11111, 2'b00, (i == 59) ? 1'b1 : 1'b0);
        // Next frame starts with clean ovf; equality gives 1
        push(1, 2, 2, 1, 0);
        send_beat(5'b00011, 2'b11, 1'b1);

        // All-zero frame
        push(1, 0, 0, 1, 0);
        send_beat(5'b00000, 2'b00, 1'b1);

        // Reset mid-frame discards the partial frame
        send_beat(5'b11111, 2'b11, 1'b0);
        send_beat(5'b11111, 2'b11, 1'b0);
        i_rst_n = 1'b0;
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
`ifdef PCC_TRUNC_EN
        push(1, 0, 1, 1, 0);
`else
        push(0, 0, 1, 1, 0);
`endif
        send_beat(5'b00000, 2'b01, 1'b1);

        repeat (5) @(posedge i_clk);
        #1;
        chk("scoreboard_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pcc_stream_acc.md
Name: pcc_stream_acc

Overview:
- Streaming, multi-beat successor to the single-shot popcount comparator (pcc).
- Accepts a frame of one or more beats, each carrying POS_W positive and NEG_W negative bits.
- Accumulates both popcounts across the frame and emits one decision per frame: total positive count >= total negative count.
- Sits between the bit-vector producer and the decision consumer; valid/ready on both sides.

Parameters:
- POS_W, 5, width of positive input vector per beat.
- NEG_W, 2, width of negative input vector per beat.
- ACC_W, 8, width of each frame accumulator and of the count outputs.
- BEAT_W, 6, width of the frame beat counter.
- TRUNC, 1, LSBs dropped from both totals before compare; only used when PCC_TRUNC_EN is defined. Must be < ACC_W.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  beat present.
- in_ready  out  1  block can accept a beat.
- in_pos  in  POS_W  positive bits of the beat.
- in_neg  in  NEG_W  negative bits of the beat.
- in_last  in  1  beat closes the frame.
- out_valid  out  1  frame result present.
- out_ready  in  1  consumer takes the result.
- out_val  out  1  decision: pos_total >= neg_total.
- out_pos_cnt  out  ACC_W  frame positive total (saturated, untruncated).
- out_neg_cnt  out  ACC_W  frame negative total (saturated, untruncated).
- out_beats  out  BEAT_W  beats in frame (saturated).
- out_ovf  out  1  any accumulator or beat counter saturated during frame.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is synchronous and active-low.
- Reset values (rst_n=0 at a clk edge):
  - state=ACCUM; acc_pos=acc_neg=0; beats=0; ovf=0.
  - out_valid=0; out_val=0; out_pos_cnt=out_neg_cnt=0; out_beats=0; out_ovf=0.
- Reset mid-frame discards the partial frame and any pending result.
- States: ACCUM, HOLD.
- in_ready = (state==ACCUM). Combinational from state only; never depends on in_valid.
- Accept = in_valid && in_ready.
- ACCUM, accept with in_last=0:
  - acc_pos += popcount(in_pos); acc_neg += popcount(in_neg); beats += 1.
  - Each counter saturates at all-ones; on saturation set sticky ovf.
- ACCUM, accept with in_last=1:
  - Compute final totals as above, including this beat.
  - Register them onto the out_* ports; out_ovf = ovf OR saturation this beat.
  - out_valid=1 next cycle; state -> HOLD.
  - Clear acc_pos, acc_neg, beats and ovf.
- Latency: last beat accepted at edge N; out_valid=1 and outputs stable after edge N.
- A single-beat frame (in_last on first beat) is legal.
- HOLD:
  - out_* held stable while out_valid=1 && out_ready=0.
  - On out_ready=1: out_valid=0 at the next edge; state -> ACCUM; in_ready=1 from that edge.
  - No beat is accepted in HOLD.
- Compare: out_val = (P >= N), where P and N are the saturated totals. Equality -> 1. A frame with all-zero inputs -> out_val=1.
- in_pos, in_neg and in_last are ignored when accept=0.
- Sustained throughput is at most one frame per (beats + 1) cycles.

Optional Feature:
- Macro: PCC_TRUNC_EN.
- Defined: compare uses P>>TRUNC >= N>>TRUNC (approximate compare, cheaper comparator). out_pos_cnt and out_neg_cnt still report untruncated totals.
- Undefined: exact compare; TRUNC is unused.

Test Plan:
- Reset then single beat in_pos=5'b10110, in_neg=2'b11, in_last=1, out_ready=1:
  - out_valid one cycle after accept; out_pos_cnt=3, out_neg_cnt=2, out_val=1, out_beats=1, out_ovf=0.
- 3-beat frame, pos popcounts 1,0,1 and neg popcounts 2,1,0 (totals P=2, N=3):
  - out_val=0, out_beats=3; in_ready=0 while result is pending.
- Backpressure: hold out_ready=0 for 5 cycles after the result:
  - out_* stable, in_ready=0, in_valid beats not consumed.
  - out_ready=1 -> out_valid drops next edge, in_ready=1.
- Saturation: 60 beats of in_pos=5'b11111, in_neg=0, ACC_W=8:
  - out_pos_cnt=255, out_ovf=1, out_val=1.
  - The next frame starts with out_ovf=0.
- Reset mid-frame: after 2 beats assert rst_n=0 for 1 cycle, then send a single beat in_pos=0, in_neg=2'b01, in_last=1:
  - Result P=0, N=1, out_val=0, out_beats=1 (no residue from the aborted frame).
- With PCC_TRUNC_EN, TRUNC=1, frame totals P=2, N=3:
  - out_val=1 (1>=1). Without the macro the same frame gives out_val=0.
